// File: rtl/ucsbece152a_taillights_gen2.sv
// Sequential taillight controller: turn/hazard animation, brake overlay and a built-in
// PWM dimmer for running lights, all feeding one registered lamp-drive bus.
module ucsbece152a_taillights_gen2 #(
    parameter int N_LAMPS  = 3,
    parameter int STEP_DIV = 4,
    parameter int PWM_BITS = 4,
    parameter int DIM_DUTY = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   left_i,
    input  logic                   right_i,
    input  logic                   hazard_i,
    input  logic                   brake_i,
    input  logic                   runlights_i,
    output logic [2*N_LAMPS-1:0]   lights_o
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = $clog2(N_LAMPS + 1);
    localparam logic [PW-1:0]     PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [SW-1:0]     LAST_STEP = SW'(N_LAMPS);
    localparam logic [PWM_BITS:0] DUTY      = (PWM_BITS + 1)'(DIM_DUTY);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

    state_t                 state_reg, state_next, req;
    logic [SW-1:0]          step_reg, step_next;
    logic [PW-1:0]          presc_reg, presc_next;
    logic [PWM_BITS-1:0]    pwm_cnt_reg;
    logic [2*N_LAMPS-1:0]   lights_reg, lights_next;
    logic [N_LAMPS-1:0]     left_lit, right_lit;
    logic                   tick, haz_on, dim;

    always_comb begin
        req = IDLE;
        if (hazard_i | (left_i & right_i)) req = HAZ;
        else if (left_i)                   req = LEFT;
        else if (right_i)                  req = RIGHT;

        // Leaving IDLE does not wait for the prescaler, so the first step shows up promptly
        tick = (presc_reg == PRESC_MAX) || ((state_reg == IDLE) && (req != IDLE));

        presc_next = ((state_reg == IDLE) || (presc_reg == PRESC_MAX)) ? '0
                                                                       : presc_reg + PW'(1);
        state_next = state_reg;
        step_next  = step_reg;

        if (tick) begin
            if (req == IDLE) begin
                state_next = IDLE;
                step_next  = '0;
            end else if (req == state_reg) begin
                if (state_reg == HAZ)
                    step_next = (step_reg == '0) ? SW'(1) : '0;
                else
                    step_next = (step_reg == LAST_STEP) ? '0 : step_reg + SW'(1);
            end else begin
                // Mode change restarts immediately at step 1, no blank step in between
                state_next = req;
                step_next  = SW'(1);
            end
        end
    end

    assign haz_on = (state_reg == HAZ) && (step_reg != '0);
    assign dim    = runlights_i && ({1'b0, pwm_cnt_reg} < DUTY);

    generate
        for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_lamp
            assign left_lit[gi]  = ((state_reg == LEFT) && (step_reg > SW'(gi))) || haz_on
                                   || (brake_i && (state_reg != LEFT));
            assign right_lit[gi] = ((state_reg == RIGHT) && (step_reg > SW'(gi))) || haz_on
                                   || (brake_i && (state_reg != RIGHT));
            assign lights_next[N_LAMPS + gi]     = left_lit[gi] | dim;
            assign lights_next[N_LAMPS - 1 - gi] = right_lit[gi] | dim;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            step_reg    <= '0;
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
            lights_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            presc_reg   <= presc_next;
            pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
            lights_reg  <= lights_next;
        end
    end

    assign lights_o = lights_reg;

endmodule
